// File: rtl/arbt_rr_sink_fifo_pkg.sv
// Shared helpers for the arbiter sink FIFO: pointer/count sizing, depth legality
// and the per-cycle push/pop operation encoding.
package arbt_rr_sink_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/arbt_rr_sink_fifo_if.sv
// Arbiter-side handshake plus downstream valid/ready stream and FIFO status.
interface arbt_rr_sink_fifo_if
  import arbt_rr_sink_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic                  flush;
  logic [DATA_WIDTH-1:0] arbt_data;
  logic                  arbt_rdy;
  logic                  arbt_ack;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;

  modport master (
    output flush, arbt_data, arbt_rdy, ready,
    input  arbt_ack, data, valid, count, full, empty, almost_full
  );

  modport slave (
    input  flush, arbt_data, arbt_rdy, ready,
    output arbt_ack, data, valid, count, full, empty, almost_full
  );

endinterface

// File: rtl/arbt_rr_sink_fifo_mem.sv
// DEPTH x DATA_WIDTH flop array: synchronous write, asynchronous read.
module fifo_mem_1w1r
  import arbt_rr_sink_fifo_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  localparam int                   AW         = ptr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/arbt_rr_sink_fifo.sv
// FWFT FIFO between the round-robin arbiter and the next stage; acks the arbiter
// only when a slot is free, so downstream backpressure never reaches arbitration.
module arbt_rr_sink_fifo
  import arbt_rr_sink_fifo_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter int                    AF_THRESH  = DEPTH - 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  arbt_rr_sink_fifo_if.slave bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  fifo_op_e         op;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Ack never depends on ready: it sees only registered full, flush and arbiter
  // inputs. Reset is folded in so a word offered during reset is not dropped.
  assign push = rst_ni & bus.arbt_rdy & ~full & ~bus.flush;
  assign pop  = ~empty & bus.ready & ~bus.flush;
  assign op   = fifo_op_e'({push, pop});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case (op)
        OP_PUSH: count <= count + CNT_W'(1);
        OP_POP:  count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  fifo_mem_1w1r #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .RESET_VAL  (RESET_VAL)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we     (push),
    .waddr  (wr_ptr),
    .wdata  (bus.arbt_data),
    .raddr  (rd_ptr),
    .rdata  (bus.data)
  );

  assign bus.arbt_ack    = push;
  assign bus.valid       = ~empty;
  assign bus.count       = count;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (32'(count) >= AF_THRESH);

`ifndef SYNTHESIS
  a_depth_pow2: assert property (@(posedge clk_i) is_pow2(DEPTH));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && empty));
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= CNT_W'(DEPTH));
  a_ack_rdy: assert property (@(posedge clk_i) disable iff (!rst_ni) bus.arbt_ack |-> bus.arbt_rdy);
  a_data_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.valid && !bus.ready && !bus.flush) |=> $stable(bus.data));
`endif

endmodule

// File: tb/tb_arbt_rr_sink_fifo.sv
// Table-driven bench for the arbiter sink FIFO with a word-order scoreboard.
module tb_arbt_rr_sink_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  typedef struct {
    logic          rdy;
    logic [DW-1:0] data;
    logic          dn_rdy;
    logic          flush;
    logic          exp_ack;
    int            exp_cnt;
  } vec_t;

  logic clk    = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  arbt_rr_sink_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bif ();

  arbt_rr_sink_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .RESET_VAL  (32'h0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bif)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] sb[$];
  vec_t          vecs[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic r, logic [DW-1:0] d, logic dn, logic f, logic a, int c);
    vec_t v;
    v.rdy = r; v.data = d; v.dn_rdy = dn; v.flush = f; v.exp_ack = a; v.exp_cnt = c;
    return v;
  endfunction

  task automatic chk_status(input string tag, input int c);
    chk({tag, " count"}, DW'(bif.count), DW'(c));
    chk({tag, " full"},  DW'(bif.full),  DW'(c == DEPTH));
    chk({tag, " empty"}, DW'(bif.empty), DW'(c == 0));
    chk({tag, " afull"}, DW'(bif.almost_full), DW'(c >= AF));
  endtask

  task automatic step(input vec_t v, input string tag);
    logic exp_pop;
    @(negedge clk);
    bif.arbt_rdy  = v.rdy;
    bif.arbt_data = v.data;
    bif.ready     = v.dn_rdy;
    bif.flush     = v.flush;
    #1;
    chk({tag, " ack"}, DW'(bif.arbt_ack), DW'(v.exp_ack));
    if (sb.size() > 0) begin
      chk({tag, " valid"}, DW'(bif.valid), DW'(1));
      chk({tag, " data"}, bif.data, sb[0]);
    end else begin
      chk({tag, " valid"}, DW'(bif.valid), DW'(0));
    end
    exp_pop = v.dn_rdy && !v.flush && (sb.size() > 0);
    @(posedge clk);
    if (v.flush) sb.delete();
    else begin
      if (exp_pop) void'(sb.pop_front());
      if (v.exp_ack) sb.push_back(v.data);
    end
    #1;
    chk_status(tag, v.exp_cnt);
  endtask

  initial begin
    bif.arbt_rdy  = 1'b0;
    bif.arbt_data = '0;
    bif.ready     = 1'b0;
    bif.flush     = 1'b0;
    rst_ni        = 1'b0;

    // Reset state, checked both while held and just after release.
    #7;
    chk_status("rst_hold", 0);
    chk("rst_hold valid", DW'(bif.valid), DW'(0));
    chk("rst_hold ack", DW'(bif.arbt_ack), DW'(0));
    chk("rst_hold data", bif.data, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    chk_status("rst_rel", 0);
    chk("rst_rel valid", DW'(bif.valid), DW'(0));
    chk("rst_rel ack", DW'(bif.arbt_ack), DW'(0));

    // Fill to full with ready low, fifth word blocked until one pop.
    vecs.push_back(mkv(1, 32'hA, 0, 0, 1, 1));
    vecs.push_back(mkv(1, 32'hB, 0, 0, 1, 2));
    vecs.push_back(mkv(1, 32'hC, 0, 0, 1, 3));
    vecs.push_back(mkv(1, 32'hD, 0, 0, 1, 4));
    vecs.push_back(mkv(1, 32'hE, 0, 0, 0, 4));
    vecs.push_back(mkv(1, 32'hE, 0, 0, 0, 4));
    vecs.push_back(mkv(1, 32'hE, 1, 0, 0, 3));
    vecs.push_back(mkv(1, 32'hE, 0, 0, 1, 4));
    vecs.push_back(mkv(0, 32'h0, 1, 0, 0, 3));
    vecs.push_back(mkv(0, 32'h0, 1, 0, 0, 2));
    // Simultaneous push/pop at count 2, streaming 0..9 across pointer wrap.
    for (int i = 0; i < 10; i++) vecs.push_back(mkv(1, DW'(i), 1, 0, 1, 2));
    vecs.push_back(mkv(0, 32'h0, 1, 0, 0, 1));
    vecs.push_back(mkv(0, 32'h0, 1, 0, 0, 0));
    // Flush at count 3 with rdy and ready both high.
    vecs.push_back(mkv(1, 32'h10, 0, 0, 1, 1));
    vecs.push_back(mkv(1, 32'h11, 0, 0, 1, 2));
    vecs.push_back(mkv(1, 32'h12, 0, 0, 1, 3));
    vecs.push_back(mkv(1, 32'h13, 1, 1, 0, 0));
    vecs.push_back(mkv(1, 32'h14, 0, 0, 1, 1));
    vecs.push_back(mkv(0, 32'h0, 1, 0, 0, 0));
    // Two words in before the mid-stream reset.
    vecs.push_back(mkv(1, 32'h20, 0, 0, 1, 1));
    vecs.push_back(mkv(1, 32'h21, 0, 0, 1, 2));

    foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset with count 2 and the arbiter still offering a word.
    @(negedge clk);
    bif.arbt_rdy  = 1'b1;
    bif.arbt_data = 32'h22;
    bif.ready     = 1'b0;
    #1;
    chk("pre_rst ack", DW'(bif.arbt_ack), DW'(1));
    chk("pre_rst data", bif.data, 32'h20);
    rst_ni = 1'b0;
    #1;
    chk_status("mid_rst", 0);
    chk("mid_rst valid", DW'(bif.valid), DW'(0));
    chk("mid_rst ack", DW'(bif.arbt_ack), DW'(0));
    chk("mid_rst data", bif.data, 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    chk_status("mid_rst_edge", 0);
    @(negedge clk);
    bif.arbt_rdy = 1'b0;
    rst_ni       = 1'b1;
    step(mkv(1, 32'h30, 0, 0, 1, 1), "post_rst0");
    step(mkv(0, 32'h0, 1, 0, 0, 0), "post_rst1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
